hdmi_video_sched: RTL and testbench
===================================

# hdmi_video_sched

Generates raster timing and sequences the three `tmds_enc` channels of the HDMI transmitter through control, preamble, guard-band and video periods. It pulls pixels from an upstream show-ahead FIFO. It drives each encoder's `px_data_i`, `px_data_val_i`, `ctl_0_i` and `ctl_1_i`. It emits a guard-band flag aligned to encoder output for the downstream symbol mux.

## Interface
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (cycles)
- `H_SYNC`, 40, hsync width
- `H_BP`, 220, horizontal back porch; ≥ 12 when `HDMI_MODE`=1
- `V_ACTIVE`, 720, active lines
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `HS_POL`, 1, hsync active level
- `VS_POL`, 1, vsync active level
- `HDMI_MODE`, 1, 1 = insert preamble and guard band; 0 = DVI (control/video only)
- `ENC_LATENCY`, 4, `tmds_enc` input-to-`tmds_data_o` latency in cycles
- `clk_i`, in, 1, pixel clock
- `rst_i`, in, 1, reset, asynchronous, active-high
- `en_i`, in, 1, run enable
- `px_data_i`, in, 24, {R,G,B} pixel at FIFO head (show-ahead)
- `px_empty_i`, in, 1, FIFO empty
- `px_rd_o`, out, 1, FIFO pop; `px_data_i` is consumed in the same cycle
- `ch0_data_o`/`ch1_data_o`/`ch2_data_o`, out, 8, B/G/R to encoders 0/1/2
- `ch_val_o`, out, 1, video-period valid (common to all channels)
- `ch0_ctl_o`, `ch1_ctl_o`, `ch2_ctl_o`, out, 2, {ctl_1, ctl_0} per encoder
- `guard_o`, out, 1, guard-band symbol due on `tmds_data_o`, aligned to encoder output
- `frame_start_o`, out, 1, pulse with first pixel of the frame on `ch*_data_o`
- `underflow_o`, out, 1, sticky FIFO underflow flag

## Operation
- Line timing: counter `h` runs 0..H_TOT-1, where H_TOT = sum of the H parameters. Regions in order: active [0,H_ACTIVE), front porch, sync, back porch.
- Frame timing: counter `v` runs 0..V_TOT-1 in the same region order. `v` advances when `h` wraps. Counter widths are `$clog2(total)`.
- Line type: `next_active` = (v==V_TOT-1) || (v<V_ACTIVE-1), evaluated at the line's end.
- FSM states:
  - IDLE: entered while `en_i`=0. Counters are held at h=0, v=V_TOT-1, so the first frame gets a full preamble.
  - CTRL: default blanking state.
  - PREAMBLE: h∈[H_TOT-10, H_TOT-2) with `next_active`.
  - GUARD: h∈[H_TOT-2, H_TOT) with `next_active`.
  - VIDEO: h<H_ACTIVE and v<V_ACTIVE.
  - With `HDMI_MODE`=0, PREAMBLE and GUARD become CTRL.
- Channel 0 control: `ch0_ctl_o` = {vsync, hsync}.
  - hsync is active in the h-sync region.
  - vsync is active for all cycles of lines in the v-sync region.
  - Each is driven at its `_POL` level when active.
- Channels 1 and 2 control:
  - PREAMBLE: `ch1_ctl_o`=2'b01, `ch2_ctl_o`=2'b00 (CTL0..3 = 1,0,0,0; video preamble).
  - Otherwise 2'b00.
- `ch_val_o`: 1 only in VIDEO. In GUARD, `ch_val_o`=0 and ctl=00; the downstream mux replaces the symbol using `guard_o`.
- `px_rd_o`: combinational decode of registered counters, equal to (state==VIDEO).
  - If `px_empty_i` is also set, the pixel output is forced to 0 and `underflow_o` is set.
  - `underflow_o` is cleared only by reset or `en_i`=0.
- Deasserting `en_i` mid-frame: next cycle the block enters IDLE, counters are reloaded, and syncs go inactive. No partial-frame recovery.
- Guard-band codes for the downstream mux: ch0 10'b1011001100, ch1 10'b0100110011, ch2 10'b1011001100.

## Timing
- Reset values:
  - counters h=0, v=V_TOT-1; state IDLE.
  - `ch*_data_o`=0, `ch_val_o`=0, `px_rd_o`=0, `guard_o`=0, `frame_start_o`=0, `underflow_o`=0.
  - `ch0_ctl_o` = {~VS_POL, ~HS_POL}; `ch1_ctl_o` = `ch2_ctl_o` = 00.
- All outputs except `px_rd_o` are registered: the counter state in cycle t appears on the outputs at t+1.
- `px_data_i` sampled with `px_rd_o` in cycle t appears on `ch*_data_o` at t+1.
- `guard_o` is the registered GUARD indication delayed by a further ENC_LATENCY cycles. It is high exactly 2 cycles per active line, immediately preceding the first video symbol on `tmds_data_o`.
- `frame_start_o` is high for 1 cycle, coincident with `ch_val_o` for h=0, v=0.
- `en_i` rising edge: the first PREAMBLE starts H_TOT-10 cycles after entering CTRL at h=0 of line V_TOT-1 (+1 output register).

## Structure
- Package `hdmi_pkg` holds:
  - `period_t` enum {IDLE, CTRL, PREAMBLE, GUARD, VIDEO}
  - guard-band code constants per channel
  - preamble CTL constants
  - preamble length 8 and guard length 2
- Sub-module `video_timing_cnt` contains the h/v counters with wrap and hold/reload. It outputs `h`, `v`, `line_end` and `next_active`.
- The guard-delay shift register is ENC_LATENCY bits deep.

## Test plan
- Use small timing for all runs: H 16/2/4/14 (H_TOT=36), V 4/1/2/2 (V_TOT=9), FIFO never empty.
  - Required per active line: 16 `ch_val_o` cycles and 8 cycles of `ch1_ctl_o`=01 ending 2 cycles before `ch_val_o`.
  - Required per frame: 324 cycles.
- Reset release with `en_i`=1, incrementing pixels → `frame_start_o` and the first `ch_val_o` occur together, with `ch0_data_o`=px[7:0] of the first FIFO word.
- `guard_o` check: high at output cycles c+4 and c+5, where c is the first GUARD output cycle. Exactly 2 high cycles per active line, 0 on blanking lines.
- `HDMI_MODE`=0 → no 01 on `ch1_ctl_o`, `guard_o` never high, video timing unchanged.
- Hsync/vsync check with HS_POL=0:
  - `ch0_ctl_o[0]`=0 for h∈[18,22) on every line.
  - `ch0_ctl_o[1]` active for the full 36 cycles of lines v=5 and v=6.
- `px_empty_i`=1 for one VIDEO cycle → `ch*_data_o`=0 that cycle, `underflow_o` stays 1 until `en_i`=0. A reset asserted mid-line forces all outputs to their reset values immediately.

Source files
------------

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and constants for the HDMI video scheduler
package hdmi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        PREAMBLE,
        GUARD,
        VIDEO
    } period_t;

    // Guard-band symbols substituted by the downstream symbol mux
    localparam logic [9:0] GB_CODE_CH0 = 10'b1011001100;
    localparam logic [9:0] GB_CODE_CH1 = 10'b0100110011;
    localparam logic [9:0] GB_CODE_CH2 = 10'b1011001100;

    // Video preamble: CTL0..3 = 1,0,0,0 -> ch1 {ctl_1,ctl_0}=01, ch2=00
    localparam logic [1:0] PRE_CTL_CH1 = 2'b01;
    localparam logic [1:0] PRE_CTL_CH2 = 2'b00;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

endpackage

// File: rtl/video_timing_cnt.sv
// rtl/video_timing_cnt.sv - horizontal/vertical raster counters with hold and reload
module video_timing_cnt #(
    parameter int H_TOT    = 36,
    parameter int V_TOT    = 9,
    parameter int V_ACTIVE = 4,
    parameter int HW       = 6,
    parameter int VW       = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          line_end_o,
    output logic          next_active_o
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Next count: h wraps each line, v advances on h wrap; disabled parks on the last line
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        if (!en_i) begin
            h_d = '0;
            v_d = V_LAST;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= V_LAST;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign line_end_o    = (h_q == H_LAST);
    assign next_active_o = (v_q == V_LAST) || (v_q < V_ACT_LAST);

endmodule

// File: rtl/hdmi_video_sched.sv
// rtl/hdmi_video_sched.sv - raster timing and period sequencing for three TMDS encoders
module hdmi_video_sched
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_ACTIVE    = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int HDMI_MODE   = 1,
    parameter int ENC_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [23:0] px_data_i,
    input  logic        px_empty_i,
    output logic        px_rd_o,
    output logic [7:0]  ch0_data_o,
    output logic [7:0]  ch1_data_o,
    output logic [7:0]  ch2_data_o,
    output logic        ch_val_o,
    output logic [1:0]  ch0_ctl_o,
    output logic [1:0]  ch1_ctl_o,
    output logic [1:0]  ch2_ctl_o,
    output logic        guard_o,
    output logic        frame_start_o,
    output logic        underflow_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam int unsigned H_ACT_U     = H_ACTIVE;
    localparam int unsigned V_ACT_U     = V_ACTIVE;
    localparam int unsigned HS_START    = H_ACTIVE + H_FP;
    localparam int unsigned HS_END      = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START    = V_ACTIVE + V_FP;
    localparam int unsigned VS_END      = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned PRE_START   = H_TOT - PREAMBLE_LEN - GUARD_LEN;
    localparam int unsigned GUARD_START = H_TOT - GUARD_LEN;
    localparam logic [1:0]  CTL0_IDLE   = {~VS_POL, ~HS_POL};

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          line_end;
    logic          next_active;
    logic [31:0]   hx, vx;
    period_t       period;
    logic          hs_act, vs_act, take_px;
    logic [1:0]    ctl0_d;

    period_t       state_q;
    logic [23:0]   data_q;
    logic          val_q, fs_q, uf_q;
    logic [1:0]    ctl0_q, ctl1_q, ctl2_q;
    logic [ENC_LATENCY-1:0] guard_sr_q;

    video_timing_cnt #(
        .H_TOT   (H_TOT),
        .V_TOT   (V_TOT),
        .V_ACTIVE(V_ACTIVE),
        .HW      (HW),
        .VW      (VW)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .h_o          (h),
        .v_o          (v),
        .line_end_o   (line_end),
        .next_active_o(next_active)
    );

    assign hx = 32'(h);
    assign vx = 32'(v);

    // Period decode from the current counter position
    always_comb begin
        period = CTRL;
        if (!en_i) begin
            period = IDLE;
        end else if (hx < H_ACT_U && vx < V_ACT_U) begin
            period = VIDEO;
        end else if (HDMI_MODE != 0 && next_active && (line_end || hx >= GUARD_START)) begin
            period = GUARD;
        end else if (HDMI_MODE != 0 && next_active && hx >= PRE_START) begin
            period = PREAMBLE;
        end
    end

    assign hs_act  = (hx >= HS_START) && (hx < HS_END);
    assign vs_act  = (vx >= VS_START) && (vx < VS_END);
    assign ctl0_d  = en_i ? {vs_act ? VS_POL : ~VS_POL, hs_act ? HS_POL : ~HS_POL} : CTL0_IDLE;
    assign take_px = (period == VIDEO);
    assign px_rd_o = take_px;

    // Registered period and encoder-facing outputs, one cycle behind the counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            val_q   <= 1'b0;
            ctl0_q  <= CTL0_IDLE;
            ctl1_q  <= 2'b00;
            ctl2_q  <= 2'b00;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= period;
            data_q  <= (take_px && !px_empty_i) ? px_data_i : '0;
            val_q   <= take_px;
            ctl0_q  <= ctl0_d;
            ctl1_q  <= (period == PREAMBLE) ? PRE_CTL_CH1 : 2'b00;
            ctl2_q  <= (period == PREAMBLE) ? PRE_CTL_CH2 : 2'b00;
            fs_q    <= take_px && (h == '0) && (v == '0);
            uf_q    <= en_i && (uf_q || (take_px && px_empty_i));
        end
    end

    // Delay the guard indication to line up with the encoders' output symbols
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            guard_sr_q <= '0;
        end else begin
            guard_sr_q <= {guard_sr_q[ENC_LATENCY-2:0], state_q == GUARD};
        end
    end

    assign ch0_data_o    = data_q[7:0];
    assign ch1_data_o    = data_q[15:8];
    assign ch2_data_o    = data_q[23:16];
    assign ch_val_o      = val_q;
    assign ch0_ctl_o     = ctl0_q;
    assign ch1_ctl_o     = ctl1_q;
    assign ch2_ctl_o     = ctl2_q;
    assign guard_o       = guard_sr_q[ENC_LATENCY-1];
    assign frame_start_o = fs_q;
    assign underflow_o   = uf_q;

endmodule

// File: tb/tb_hdmi_video_sched.sv
// tb/tb_hdmi_video_sched.sv - scoreboard bench for hdmi_video_sched (HDMI and DVI instances)
module tb_hdmi_video_sched;

    localparam int HT = 36;
    localparam int VT = 9;
    localparam int FR = HT * VT;
    localparam int P0 = (VT - 1) * HT;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, px_empty_i;
    logic [23:0] px_data_i;

    logic       a_rd, a_val, a_guard, a_fs, a_uf;
    logic [7:0] a_d0, a_d1, a_d2;
    logic [1:0] a_c0, a_c1, a_c2;
    logic       b_rd, b_val, b_guard, b_fs, b_uf;
    logic [7:0] b_d0, b_d1, b_d2;
    logic [1:0] b_c0, b_c1, b_c2;

    int errors = 0;
    int checks = 0;
    int word   = 0;
    int k      = 0;
    logic [23:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    hdmi_video_sched #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(14),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b1), .HDMI_MODE(1), .ENC_LATENCY(4)
    ) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .px_data_i(px_data_i), .px_empty_i(px_empty_i), .px_rd_o(a_rd),
        .ch0_data_o(a_d0), .ch1_data_o(a_d1), .ch2_data_o(a_d2), .ch_val_o(a_val),
        .ch0_ctl_o(a_c0), .ch1_ctl_o(a_c1), .ch2_ctl_o(a_c2),
        .guard_o(a_guard), .frame_start_o(a_fs), .underflow_o(a_uf)
    );

    hdmi_video_sched #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(14),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .HDMI_MODE(0), .ENC_LATENCY(4)
    ) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .px_data_i(px_data_i), .px_empty_i(px_empty_i), .px_rd_o(b_rd),
        .ch0_data_o(b_d0), .ch1_data_o(b_d1), .ch2_data_o(b_d2), .ch_val_o(b_val),
        .ch0_ctl_o(b_c0), .ch1_ctl_o(b_c1), .ch2_ctl_o(b_c2),
        .guard_o(b_guard), .frame_start_o(b_fs), .underflow_o(b_uf)
    );

    function automatic logic [23:0] pix(input int n);
        return 24'(n * 32'h030201 + 32'h112233);
    endfunction

    function automatic bit is_video(input int pos);
        int h, v;
        h = pos % HT;
        v = (pos % FR) / HT;
        return (h < 16) && (v < 4);
    endfunction

    // {val, ctl0, ctl1, ctl2, frame_start, guard} expected after the kk-th clock since restart
    function automatic logic [8:0] exp_ctrl(input int kk, input bit hdmi, input bit hpol);
        int q, h, v, q2, h2, v2;
        bit val, pre, hs, vs, fs, g, na, na2;
        q   = (P0 + kk - 1) % FR;
        h   = q % HT;
        v   = q / HT;
        na  = (v == VT - 1) || (v < 3);
        val = (h < 16) && (v < 4);
        pre = hdmi && na && (h >= 26) && (h < 34);
        hs  = (h >= 18) && (h < 22);
        vs  = (v >= 5) && (v < 7);
        fs  = (h == 0) && (v == 0);
        q2  = (P0 + kk - 5) % FR;
        h2  = q2 % HT;
        v2  = q2 / HT;
        na2 = (v2 == VT - 1) || (v2 < 3);
        g   = hdmi && na2 && (h2 >= 34);
        return {val, vs, hs ? hpol : ~hpol, pre ? 2'b01 : 2'b00, 2'b00, fs, g};
    endfunction

    // One clock: model the show-ahead FIFO and push the expected pixel when it is popped
    task automatic tick();
        bit popped;
        popped = a_rd && !px_empty_i;
        if (a_rd) sb_q.push_back(px_empty_i ? 24'h0 : px_data_i);
        @(posedge clk_i);
        #1;
        k++;
        if (popped) begin
            word++;
            px_data_i = pix(word);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; px_empty_i = 1'b0;
        word = 0; px_data_i = pix(0);
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({a_rd, a_val, a_c0, a_c1, a_c2, a_guard, a_fs, a_uf} !== 11'b00_01_00_00_000) begin
            errors++;
            $display("FAIL reset_ctrl_a got=%b want=%b", {a_rd, a_val, a_c0, a_c1, a_c2, a_guard, a_fs, a_uf}, 11'b00_01_00_00_000);
        end
        checks++;
        if ({a_d2, a_d1, a_d0} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data_a got=%h want=000000", {a_d2, a_d1, a_d0});
        end
        checks++;
        if ({b_rd, b_val, b_c0, b_c1, b_c2, b_guard, b_fs, b_uf} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl_b got=%b want=%b", {b_rd, b_val, b_c0, b_c1, b_c2, b_guard, b_fs, b_uf}, 11'b0);
        end
        rst_i = 1'b0;
        k = 0;
    endtask

    task automatic test_raster(input int nfr, input bit first);
        logic [8:0]  ea, eb, ga, gb;
        logic [23:0] exp_px, w0;
        int nval = 0, npre = 0, ng = 0, nfs = 0, bpre = 0, bg = 0;
        int last_pre = -100, run = 0;
        bit prev_val = 1'b0;
        w0 = pix(0);
        for (int i = 0; i < nfr * FR; i++) begin
            tick();
            ea = exp_ctrl(k, 1'b1, 1'b0);
            eb = exp_ctrl(k, 1'b0, 1'b1);
            ga = {a_val, a_c0, a_c1, a_c2, a_fs, a_guard};
            gb = {b_val, b_c0, b_c1, b_c2, b_fs, b_guard};
            checks++;
            if (ga !== ea) begin
                errors++;
                $display("FAIL raster_a k=%0d got=%b want=%b", k, ga, ea);
            end
            checks++;
            if (gb !== eb) begin
                errors++;
                $display("FAIL raster_b k=%0d got=%b want=%b", k, gb, eb);
            end
            checks++;
            if (a_rd !== is_video(P0 + k)) begin
                errors++;
                $display("FAIL px_rd k=%0d got=%b want=%b", k, a_rd, is_video(P0 + k));
            end
            exp_px = 24'h0;
            if (a_val === 1'b1) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty k=%0d got=empty want=pixel", k);
                end else begin
                    exp_px = sb_q.pop_front();
                end
            end
            checks++;
            if ({a_d2, a_d1, a_d0} !== exp_px || {b_d2, b_d1, b_d0} !== exp_px) begin
                errors++;
                $display("FAIL pixel k=%0d got_a=%h got_b=%h want=%h", k, {a_d2, a_d1, a_d0}, {b_d2, b_d1, b_d0}, exp_px);
            end
            if (first && a_fs === 1'b1 && nfs == 0) begin
                checks++;
                if (a_d0 !== w0[7:0] || a_val !== 1'b1) begin
                    errors++;
                    $display("FAIL first_px got=%h/%b want=%h/1", a_d0, a_val, w0[7:0]);
                end
            end
            if (a_c1 == 2'b01) last_pre = k;
            if (a_val && !prev_val) begin
                checks++;
                if (k - last_pre != 3) begin
                    errors++;
                    $display("FAIL pre_gap k=%0d got=%0d want=3", k, k - last_pre);
                end
            end
            if (!a_val && prev_val) begin
                checks++;
                if (run != 16) begin
                    errors++;
                    $display("FAIL line_len k=%0d got=%0d want=16", k, run);
                end
                run = 0;
            end
            if (a_val) run++;
            prev_val = a_val;
            nval += int'(a_val);
            npre += int'(a_c1 == 2'b01);
            ng   += int'(a_guard);
            nfs  += int'(a_fs);
            bpre += int'(b_c1 == 2'b01);
            bg   += int'(b_guard);
        end
        checks++;
        if (nval != 64 * nfr || npre != 32 * nfr || ng != 8 * nfr || nfs != nfr) begin
            errors++;
            $display("FAIL frame_counts got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", nval, npre, ng, nfs, 64 * nfr, 32 * nfr, 8 * nfr, nfr);
        end
        checks++;
        if (bpre != 0 || bg != 0) begin
            errors++;
            $display("FAIL dvi_counts got=%0d/%0d want=0/0", bpre, bg);
        end
    endtask

    task automatic test_underflow();
        logic [23:0] exp_px;
        int n = 0, uf_low = 0;
        while (!a_rd && n < 100) begin
            tick();
            n++;
            if (a_val) void'(sb_q.pop_front());
        end
        checks++;
        if (a_rd !== 1'b1) begin
            errors++;
            $display("FAIL wait_video got=%b want=1", a_rd);
        end
        px_empty_i = 1'b1;
        tick();
        px_empty_i = 1'b0;
        exp_px = (sb_q.size() != 0) ? sb_q.pop_front() : 24'hFFFFFF;
        checks++;
        if ({a_d2, a_d1, a_d0} !== 24'h0 || exp_px !== 24'h0 || a_val !== 1'b1 || a_uf !== 1'b1) begin
            errors++;
            $display("FAIL underflow_hit got=%h/%b/%b want=000000/1/1", {a_d2, a_d1, a_d0}, a_val, a_uf);
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            exp_px = 24'h0;
            if (a_val) exp_px = (sb_q.size() != 0) ? sb_q.pop_front() : 24'hFFFFFF;
            checks++;
            if ({a_d2, a_d1, a_d0} !== exp_px) begin
                errors++;
                $display("FAIL pixel_after_uf i=%0d got=%h want=%h", i, {a_d2, a_d1, a_d0}, exp_px);
            end
            if (a_uf !== 1'b1) uf_low++;
        end
        checks++;
        if (uf_low != 0) begin
            errors++;
            $display("FAIL underflow_sticky got=%0d low cycles want=0", uf_low);
        end
    endtask

    task automatic test_restart();
        en_i = 1'b0;
        tick();
        checks++;
        if ({a_val, a_c0, a_c1, a_uf, a_rd} !== 7'b0_01_00_00) begin
            errors++;
            $display("FAIL idle_outputs got=%b want=%b", {a_val, a_c0, a_c1, a_uf, a_rd}, 7'b0_01_00_00);
        end
        repeat (7) tick();
        sb_q.delete();
        en_i = 1'b1;
        k = 0;
        test_raster(1, 1'b0);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!a_val && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (a_val !== 1'b1) begin
            errors++;
            $display("FAIL wait_val got=%b want=1", a_val);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({a_rd, a_val, a_c0, a_c1, a_c2, a_guard, a_fs, a_uf, a_d2, a_d1, a_d0} !== {11'b00_01_00_00_000, 24'h0}) begin
            errors++;
            $display("FAIL async_reset_a got=%b want=%b", {a_rd, a_val, a_c0, a_c1, a_c2, a_guard, a_fs, a_uf}, 11'b00_01_00_00_000);
        end
        checks++;
        if ({b_rd, b_val, b_c0, b_c1, b_c2, b_guard, b_fs, b_uf} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset_b got=%b want=0", {b_rd, b_val, b_c0, b_c1, b_c2, b_guard, b_fs, b_uf});
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_raster(2, 1'b1);
        test_underflow();
        test_restart();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
